run_length_detector: RTL and testbench
======================================

Name: run_length_detector

Overview:
Parametrised, multi-channel successor to the single-bit "count consecutive ones" FSM. Each channel tracks the length of the current run of 1s on its input bit and asserts its detect output once the run reaches THRESHOLD. Output timing is selectable as Moore (state-based) or Mealy (input-based). Sits on serial status/flag streams; feeds interrupt and event logic via `pulse` and `any_out`.

Parameters:
- CHANNELS, 1, number of independent input bit streams.
- THRESHOLD, 2, consecutive 1s required to assert `out`. Legal range 1..2^CNT_WIDTH-1; an out-of-range value is an elaboration error.
- CNT_WIDTH, 8, width of each per-channel run-length counter.
- MEALY, 0, output mode: 0 = Moore, 1 = Mealy.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  sample enable, common to all channels; when 0 all state holds.
- clear  in  1  synchronous clear of all channels; priority over en.
- in  in  CHANNELS  input bit streams, bit i = channel i.
- out  out  CHANNELS  detect, bit i = channel i run >= THRESHOLD.
- pulse  out  CHANNELS  one-cycle strobe on each 0->1 transition of out[i].
- run_len  out  CHANNELS*CNT_WIDTH  saturating run length; channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].
- any_out  out  1  OR-reduction of out.

Behaviour:
- Per-channel state is the counter `cnt`. The FSM view is derived from it:
  - IDLE: cnt == 0.
  - RUN: 0 < cnt < THRESHOLD.
  - DETECT: cnt >= THRESHOLD.
- Counter update per posedge, in priority order:
  - clear: cnt <= 0.
  - else en & in[i]: cnt <= cnt+1, saturating at 2^CNT_WIDTH-1 with no wrap.
  - else en & !in[i]: cnt <= 0.
  - else: hold.
- Transitions:
  - IDLE -> RUN, or directly to DETECT if THRESHOLD == 1, on a sampled 1.
  - RUN -> DETECT when the THRESHOLD-th consecutive 1 is sampled.
  - Any state -> IDLE on a sampled 0 or on clear.
  - DETECT holds while 1s continue, including after saturation.
- run_len[i] = cnt, registered.
- Moore mode (MEALY=0):
  - out[i] = (cnt >= THRESHOLD), a pure function of registered state.
  - Latency: out rises the cycle after the edge that samples the THRESHOLD-th 1. For THRESHOLD=2, 1s sampled at edges k and k+1 give out high after edge k+1.
  - out falls after the edge that samples the 0.
- Mealy mode (MEALY=1):
  - While en=1: out[i] = in[i] & (cnt >= THRESHOLD-1) & !clear. out is high in the same cycle the THRESHOLD-th 1 is presented, and low in the same cycle a 0 is presented.
  - While en=0: out[i] = (cnt >= THRESHOLD) & !clear, i.e. held state.
- pulse[i] = out[i] & !out_d[i], where out_d is out registered every cycle regardless of en. In Mealy mode pulse is combinational.
- any_out = |out, combinational.
- Reset (rst_n low, asynchronous):
  - All counters and out_d reset to 0.
  - out, pulse, run_len and any_out are all 0 while rst_n is low; the Mealy term is gated with rst_n.
  - Reset mid-run discards the run; after release, counting restarts from 0.
- Boundary conditions:
  - clear and en & in in the same cycle: clear wins, cnt becomes 0.
  - en low in the middle of a run: the run is not broken; counting resumes on the next enabled 1.
  - Saturation: run_len sticks at max; out stays high; no pulse is re-issued.
  - Channels are fully independent; simultaneous detects on several channels all assert.

Test Plan:
- Moore, THRESHOLD=2, CNT_WIDTH=8, CHANNELS=1, en=1, in=0,1,1,1,0 -> run_len after each edge 0,1,2,3,0; out 0,0,1,1,0; pulse high only in the cycle after the 2nd 1.
- Mealy, same stream -> out high during the cycles presenting the 2nd and 3rd 1 and low when the 0 is presented; pulse coincides with the 2nd 1.
- CNT_WIDTH=3, THRESHOLD=5, in=1 for 12 cycles -> run_len climbs to 7 and holds; out rises after the 5th 1 and stays high; exactly one pulse.
- en gating: in=1, en=1,0,0,1 with THRESHOLD=2 -> run_len 1,1,1,2; out asserts after the 4th edge; run not broken by en=0.
- clear and rst_n: run_len=3 with out high, assert clear together with in=1 -> run_len=0, out=0 next cycle. Assert rst_n low asynchronously mid-cycle -> all outputs 0 immediately; after release, counting restarts from 0.
- CHANNELS=4, THRESHOLD=1, in=4'b0101 then 4'b0111 -> out=0101 then 0111; pulse=0101 then 0010; any_out=1 throughout.

Source files
------------

// File: rtl/run_length_detector.sv
// Multi-channel run-of-ones detector: per-channel saturating run counters with
// Moore or Mealy detect timing, rising-edge strobes and an any-channel flag.
module run_length_detector #(
  parameter int unsigned CHANNELS  = 1,
  parameter int unsigned THRESHOLD = 2,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned MEALY     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clear,
  input  logic [CHANNELS-1:0]           in,
  output logic [CHANNELS-1:0]           out,
  output logic [CHANNELS-1:0]           pulse,
  output logic [CHANNELS*CNT_WIDTH-1:0] run_len,
  output logic                          any_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] THR        = CNT_WIDTH'(THRESHOLD);
  localparam bit                   MEALY_MODE = (MEALY != 0);

  // THRESHOLD must be representable in the counter and non-zero.
  if (THRESHOLD == 0 || (THRESHOLD >> CNT_WIDTH) != 0) begin : g_bad_threshold
    $error("run_length_detector: THRESHOLD out of range for CNT_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DETECT
  } phase_t;

  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]  out_d_q;
  phase_t               phase [CHANNELS];
  logic [CHANNELS-1:0]  near_detect;

  // State register: run counters and the delayed detect used for edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= '0;
      end
      out_d_q <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      out_d_q <= out;
    end
  end

  // Next counter value and the FSM phase derived from the current count.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_d[i]       = cnt_q[i];
      phase[i]       = IDLE;
      near_detect[i] = 1'b0;

      if (clear) begin
        cnt_d[i] = '0;
      end else if (en) begin
        if (in[i]) begin
          cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_WIDTH'(1);
        end else begin
          cnt_d[i] = '0;
        end
      end

      if (cnt_q[i] == '0) begin
        phase[i] = IDLE;
      end else if (cnt_q[i] < THR) begin
        phase[i] = RUN;
      end else begin
        phase[i] = DETECT;
      end

      // One more 1 would reach the threshold (cnt >= THRESHOLD-1).
      near_detect[i] = ({1'b0, cnt_q[i]} + (CNT_WIDTH+1)'(1)) >= {1'b0, THR};
    end
  end

  // Detect output: state-based in Moore mode, input-qualified in Mealy mode.
  always_comb begin
    out = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (MEALY_MODE) begin
        if (en) begin
          out[i] = in[i] & near_detect[i] & ~clear & rst_n;
        end else begin
          out[i] = (phase[i] == DETECT) & ~clear & rst_n;
        end
      end else begin
        out[i] = (phase[i] == DETECT);
      end
    end
  end

  always_comb begin
    run_len = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      run_len[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

  assign pulse   = out & ~out_d_q;
  assign any_out = |out;

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: four configurations driven in lockstep and
// compared every cycle against a run-length reference model.
module tb_run_length_detector;

  localparam int NI = 4;
  localparam int NC = 4;
  localparam int THR [NI] = '{2, 2, 5, 1};
  localparam int WID [NI] = '{8, 8, 3, 8};
  localparam int MEA [NI] = '{0, 1, 0, 1};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          clear;
  logic [NC-1:0] in;

  logic [NC-1:0] out_o   [NI];
  logic [NC-1:0] pulse_o [NI];
  logic          any_o   [NI];
  logic [31:0]   rl      [NI];
  logic [11:0]   rl_sat;

  int n_checks = 0;
  int n_errors = 0;

  // Model: length of the current run of enabled 1s, unbounded.
  int run      [NI][NC];
  bit prev_out [NI][NC];
  bit cur_out  [NI][NC];

  always #5 clk = ~clk;

  assign rl[2] = {20'd0, rl_sat};

  run_length_detector #(.CHANNELS(NC), .THRESHOLD(2), .CNT_WIDTH(8), .MEALY(0)) u_moore (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in(in),
    .out(out_o[0]), .pulse(pulse_o[0]), .run_len(rl[0]), .any_out(any_o[0]));

  run_length_detector #(.CHANNELS(NC), .THRESHOLD(2), .CNT_WIDTH(8), .MEALY(1)) u_mealy (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in(in),
    .out(out_o[1]), .pulse(pulse_o[1]), .run_len(rl[1]), .any_out(any_o[1]));

  run_length_detector #(.CHANNELS(NC), .THRESHOLD(5), .CNT_WIDTH(3), .MEALY(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in(in),
    .out(out_o[2]), .pulse(pulse_o[2]), .run_len(rl_sat), .any_out(any_o[2]));

  run_length_detector #(.CHANNELS(NC), .THRESHOLD(1), .CNT_WIDTH(8), .MEALY(1)) u_t1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in(in),
    .out(out_o[3]), .pulse(pulse_o[3]), .run_len(rl[3]), .any_out(any_o[3]));

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_out(input int k, input int c);
    if (!rst_n) return 1'b0;
    if (MEA[k] != 0) begin
      if (en) return in[c] && !clear && (run[k][c] + 1 >= THR[k]);
      return (run[k][c] >= THR[k]) && !clear;
    end
    return run[k][c] >= THR[k];
  endfunction

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      logic [NC-1:0] e_out;
      logic [NC-1:0] e_pulse;
      e_out   = '0;
      e_pulse = '0;
      for (int c = 0; c < NC; c++) begin
        int          sat_max;
        int          e_rl;
        int unsigned got_rl;
        sat_max       = (1 << WID[k]) - 1;
        e_rl          = (run[k][c] > sat_max) ? sat_max : run[k][c];
        got_rl        = (rl[k] >> (c * WID[k])) & sat_max;
        cur_out[k][c] = exp_out(k, c);
        e_out[c]      = cur_out[k][c];
        e_pulse[c]    = cur_out[k][c] & !prev_out[k][c];
        check($sformatf("run_len[i%0d.c%0d]", k, c), got_rl, e_rl);
      end
      check($sformatf("out[i%0d]", k), out_o[k], e_out);
      check($sformatf("pulse[i%0d]", k), pulse_o[k], e_pulse);
      check($sformatf("any_out[i%0d]", k), any_o[k], |e_out);
    end
  endtask

  // One cycle: drive, check mid-cycle, advance the model at the edge.
  task automatic step(input bit e, input bit cl, input logic [NC-1:0] i);
    en    = e;
    clear = cl;
    in    = i;
    @(negedge clk);
    check_all();
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < NC; c++) begin
        if (!rst_n || cl) run[k][c] = 0;
        else if (e) run[k][c] = i[c] ? run[k][c] + 1 : 0;
        prev_out[k][c] = rst_n ? cur_out[k][c] : 1'b0;
      end
    end
    #1;
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < NC; c++) begin
        run[k][c]      = 0;
        prev_out[k][c] = 1'b0;
      end
    end
    #1 check_all();
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 4'b1111);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    in    = '0;
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < NC; c++) begin
        run[k][c]      = 0;
        prev_out[k][c] = 1'b0;
        cur_out[k][c]  = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 4'b1111);
    step(1'b1, 1'b0, 4'b1010);
    rst_n = 1'b1;

    // Basic run 0,1,1,1,0.
    step(1'b1, 1'b0, 4'b0000);
    repeat (3) step(1'b1, 1'b0, 4'b1111);
    step(1'b1, 1'b0, 4'b0000);

    // Independent channels with differing patterns.
    step(1'b1, 1'b0, 4'b0101);
    step(1'b1, 1'b0, 4'b0111);
    step(1'b1, 1'b0, 4'b0000);

    // Enable gating mid-run.
    step(1'b1, 1'b0, 4'b1111);
    step(1'b0, 1'b0, 4'b1111);
    step(1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 4'b1111);

    // Long run into saturation of the narrow counter.
    repeat (10) step(1'b1, 1'b0, 4'b1111);

    // Clear against an incoming 1, and clear with en low.
    step(1'b1, 1'b1, 4'b1111);
    repeat (3) step(1'b1, 1'b0, 4'b1111);
    step(1'b0, 1'b1, 4'b1111);
    repeat (3) step(1'b1, 1'b0, 4'b1111);

    async_reset();
    repeat (3) step(1'b1, 1'b0, 4'b1111);

    for (int n = 0; n < 400; n++) begin
      logic [NC-1:0] r_in;
      for (int c = 0; c < NC; c++) r_in[c] = ($urandom_range(0, 3) != 0);
      if (n == 200) async_reset();
      step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, r_in);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
